// File: rtl/click_decoder_pkg.sv
// rtl/click_decoder_pkg.sv - shared state type and timer sizing for click_decoder
package click_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HOLD
    } click_state_t;

    // One spare bit above the largest threshold so the saturating counter never aliases it
    function automatic int ms_width(input int long_ms, input int double_ms);
        int m;
        m = (long_ms > double_ms) ? long_ms : double_ms;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/click_ms_tick.sv
// rtl/click_ms_tick.sv - millisecond prescaler with synchronous clear
module click_ms_tick #(
    parameter int CPM = 50_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (CPM > 1) ? $clog2(CPM) : 1;
    localparam logic [PW-1:0] LAST = PW'(CPM - 1);

    logic [PW-1:0] presc_q, presc_d;

    assign tick_o = (presc_q == LAST);

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (clr_i || tick_o) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/click_decoder.sv
// rtl/click_decoder.sv - single/double/long click classifier; auto-repeat under CLICK_DECODER_REPEAT_EN
module click_decoder
    import click_decoder_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int LONG_MS   = 500,
    parameter int DOUBLE_MS = 250,
    parameter int REPEAT_MS = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pressed,
    input  logic btn_state,
    input  logic btn_released,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic busy
);

    localparam int CPM  = CLK_HZ / 1000;
    localparam int MS_W = ms_width(LONG_MS, DOUBLE_MS);
    localparam logic [MS_W-1:0] LONG_LAST   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] DOUBLE_LAST = MS_W'(DOUBLE_MS - 1);

    if ((CLK_HZ % 1000) != 0 || CLK_HZ < 1000 || LONG_MS < 1 || DOUBLE_MS < 1 || REPEAT_MS < 1) begin : g_bad_param
        $error("click_decoder: invalid timing parameters");
    end

    click_state_t    state_q, state_d;
    logic [MS_W-1:0] ms_q, ms_d;
    logic            tick, timer_clr;
    logic            press_v, rel_v, long_hit, double_hit;
    logic            single_d, double_d, long_d;
    logic            single_q, double_q, long_q, busy_q;

    assign press_v   = btn_pressed & ~btn_released;
    assign rel_v     = btn_released & ~btn_pressed;
    assign timer_clr = (state_d != state_q);

    // Hit on the tick that would advance ms to N, so the decision lands N*CPM cycles after the event
    assign long_hit   = tick && (ms_q == LONG_LAST);
    assign double_hit = tick && (ms_q == DOUBLE_LAST);

    click_ms_tick #(
        .CPM (CPM)
    ) u_ms_tick (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (timer_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_v) state_d = PRESS1;
            end
            PRESS1: begin
                if (rel_v) begin
                    state_d = WAIT2;
                end else if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = LONG_HOLD;
                end
            end
            WAIT2: begin
                if (press_v) begin
                    state_d = PRESS2;
                end else if (double_hit) begin
                    single_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            PRESS2: begin
                if (rel_v) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end else if (long_hit) begin
                    long_d  = 1'b1;
                    state_d = LONG_HOLD;
                end
            end
            LONG_HOLD: begin
                if (rel_v || !btn_state) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ms_d = ms_q;
        if (timer_clr) begin
            ms_d = '0;
        end else if (tick && (ms_q != '1)) begin
            ms_d = ms_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ms_q     <= '0;
            single_q <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ms_q     <= ms_d;
            single_q <= single_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign busy         = busy_q;

`ifdef CLICK_DECODER_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_MS) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_hit, repeat_d, repeat_q;

    assign rep_hit = tick && (rep_q == REP_LAST);

    // A release on the repeat boundary leaves LONG_HOLD, which suppresses that repeat
    always_comb begin
        repeat_d = (state_q == LONG_HOLD) && (state_d == LONG_HOLD) && rep_hit;
        rep_d    = rep_q;
        if (timer_clr || (state_q != LONG_HOLD) || rep_hit) begin
            rep_d = '0;
        end else if (tick) begin
            rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q    <= '0;
            repeat_q <= 1'b0;
        end else begin
            rep_q    <= rep_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_tick = repeat_q;
`else
    assign repeat_tick = 1'b0;
`endif

endmodule

// File: tb/tb_click_decoder.sv
// tb/tb_click_decoder.sv - directed self-checking bench for click_decoder
module tb_click_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_pressed = 1'b0;
    logic btn_state = 1'b0;
    logic btn_released = 1'b0;
    logic single_click, double_click, long_press, repeat_tick, busy;

    click_decoder #(
        .CLK_HZ    (10_000),
        .LONG_MS   (50),
        .DOUBLE_MS (20),
        .REPEAT_MS (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pressed  (btn_pressed),
        .btn_state    (btn_state),
        .btn_released (btn_released),
        .single_click (single_click),
        .double_click (double_click),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int n_single, n_double, n_long, n_rep, n_busy, n_multi;
    int first_single, first_double, first_long, first_rep, last_rep;
    logic busy_log [0:1100];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        btn_pressed  = 1'b0;
        btn_released = 1'b0;
        btn_state    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Cycle t drives inputs; outputs seen #1 after that edge belong to cycle t+1. -1 = unused event.
    task automatic run_gesture(input int p0, input int r0, input int p1, input int r1,
                               input int rst_at, input logic lvl0, input int len);
        logic lvl;
        lvl = lvl0;
        n_single = 0; n_double = 0; n_long = 0; n_rep = 0; n_busy = 0;
        first_single = -1; first_double = -1; first_long = -1; first_rep = -1; last_rep = -1;
        for (int t = 0; t < len; t++) begin
            if (t == p0 || t == p1) lvl = 1'b1;
            if (t == r0 || t == r1) lvl = 1'b0;
            btn_pressed  = (t == p0) || (t == p1);
            btn_released = (t == r0) || (t == r1);
            btn_state    = lvl;
            rst          = (t == rst_at);
            @(posedge clk);
            #1;
            if (single_click) begin n_single++; if (first_single < 0) first_single = t + 1; end
            if (double_click) begin n_double++; if (first_double < 0) first_double = t + 1; end
            if (long_press)   begin n_long++;   if (first_long < 0)   first_long = t + 1;   end
            if (repeat_tick)  begin n_rep++;    if (first_rep < 0)    first_rep = t + 1; last_rep = t + 1; end
            if (busy) n_busy++;
            if ((int'(single_click) + int'(double_click) + int'(long_press)) > 1) n_multi++;
            busy_log[t + 1] = busy;
        end
        btn_pressed  = 1'b0;
        btn_released = 1'b0;
        rst          = 1'b0;
    endtask

    initial begin
        n_multi = 0;
        @(posedge clk);
        #1;
        check_eq("rst_single", int'(single_click), 0);
        check_eq("rst_double", int'(double_click), 0);
        check_eq("rst_long",   int'(long_press), 0);
        check_eq("rst_repeat", int'(repeat_tick), 0);
        check_eq("rst_busy",   int'(busy), 0);
        rst = 1'b0;

        // 1: single click
        do_reset();
        run_gesture(0, 100, -1, -1, -1, 1'b0, 400);
        check_eq("t1_single_at", first_single, 301);
        check_eq("t1_single_n",  n_single, 1);
        check_eq("t1_double_n",  n_double, 0);
        check_eq("t1_long_n",    n_long, 0);
        check_eq("t1_busy_300",  int'(busy_log[300]), 1);
        check_eq("t1_busy_301",  int'(busy_log[301]), 0);

        // 2: double click
        do_reset();
        run_gesture(0, 50, 150, 200, -1, 1'b0, 400);
        check_eq("t2_double_at", first_double, 201);
        check_eq("t2_double_n",  n_double, 1);
        check_eq("t2_single_n",  n_single, 0);
        check_eq("t2_long_n",    n_long, 0);
        check_eq("t2_busy_201",  int'(busy_log[201]), 0);

        // 3: long press, release at 900
        do_reset();
        run_gesture(0, 900, -1, -1, -1, 1'b0, 1000);
        check_eq("t3_long_at",   first_long, 501);
        check_eq("t3_long_n",    n_long, 1);
        check_eq("t3_single_n",  n_single, 0);
        check_eq("t3_double_n",  n_double, 0);
        check_eq("t3_busy_900",  int'(busy_log[900]), 1);
        check_eq("t3_busy_901",  int'(busy_log[901]), 0);
`ifdef CLICK_DECODER_REPEAT_EN
        check_eq("t3_rep_n",     n_rep, 3);
        check_eq("t3_rep_first", first_rep, 601);
        check_eq("t3_rep_last",  last_rep, 801);
`else
        check_eq("t3_rep_n",     n_rep, 0);
`endif

        // 4a: release exactly on the long threshold cycle
        do_reset();
        run_gesture(0, 500, -1, -1, -1, 1'b0, 800);
        check_eq("t4a_long_n",    n_long, 0);
        check_eq("t4a_single_at", first_single, 701);

        // 4b: second press exactly on the WAIT2 timeout cycle
        do_reset();
        run_gesture(0, 50, 250, 300, -1, 1'b0, 500);
        check_eq("t4b_single_n",  n_single, 0);
        check_eq("t4b_double_at", first_double, 301);

        // 5a: reset during WAIT2
        do_reset();
        run_gesture(0, 50, -1, -1, 100, 1'b0, 400);
        check_eq("t5a_busy_100", int'(busy_log[100]), 1);
        check_eq("t5a_busy_101", int'(busy_log[101]), 0);
        check_eq("t5a_pulses",   n_single + n_double + n_long + n_rep, 0);

        // 5b: held through reset, no fresh press
        run_gesture(-1, -1, -1, -1, 0, 1'b1, 700);
        check_eq("t5b_busy_n", n_busy, 0);
        check_eq("t5b_pulses", n_single + n_double + n_long + n_rep, 0);

        // 6a: second press held into a long press
        do_reset();
        run_gesture(0, 50, 150, -1, -1, 1'b0, 800);
        check_eq("t6a_long_at",  first_long, 651);
        check_eq("t6a_double_n", n_double, 0);
        check_eq("t6a_single_n", n_single, 0);
        check_eq("t6a_busy_end", int'(busy), 1);
        do_reset();
        check_eq("t6a_busy_rst", int'(busy), 0);

        // 6b: press and release in the same cycle from IDLE
        run_gesture(5, 5, -1, -1, -1, 1'b0, 300);
        check_eq("t6b_busy_n", n_busy, 0);
        check_eq("t6b_pulses", n_single + n_double + n_long + n_rep, 0);

        check_eq("one_hot", n_multi, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/click_decoder.md
Name: click_decoder

Overview:
- Consumes the debounced event interface (btn_pressed / btn_state / btn_released pulses) and classifies user gestures: single click, double click, long press, with optional auto-repeat while held.
- Sits between the debouncer and application logic (menu/LED control); one instance per button.
- Fully registered one-cycle output pulses; all timing is in milliseconds, derived from a clock-rate parameter.

Parameters:
- CLK_HZ, 50_000_000, clock frequency. CPM = CLK_HZ/1000 cycles per ms; CLK_HZ must be a multiple of 1000.
- LONG_MS, 500, hold time that qualifies a long press.
- DOUBLE_MS, 250, maximum gap after a first release for a second press to count.
- REPEAT_MS, 100, auto-repeat period (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_pressed  in  1  one-cycle pulse: debounced press edge
- btn_state  in  1  debounced level, 1 = held
- btn_released  in  1  one-cycle pulse: debounced release edge
- single_click  out  1  one-cycle pulse
- double_click  out  1  one-cycle pulse
- long_press  out  1  one-cycle pulse
- repeat_tick  out  1  one-cycle pulse; constant 0 without the optional feature
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. State goes to IDLE; ms timer and prescaler clear; all outputs are 0.
- Timer:
  - Prescaler counts 0..CPM-1 and emits a ms tick on wrap.
  - The ms counter saturates, is sized by $clog2(max(LONG_MS, DOUBLE_MS)) + 1, and increments on each tick.
  - Prescaler and ms counter both clear on every state transition.
  - Effect: threshold N fires exactly N*CPM cycles after the event cycle that caused the transition.
- Input qualification:
  - btn_pressed and btn_released asserted in the same cycle: ignored (no transition).
  - btn_state is used only for the checks described below.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD.
  - IDLE:
    - btn_pressed goes to PRESS1.
    - A button already held at reset is not recognised; a fresh btn_pressed is required.
  - PRESS1:
    - btn_released goes to WAIT2.
    - Otherwise, at ms == LONG_MS: pulse long_press and go to LONG_HOLD.
    - Release in the same cycle as the threshold: release wins (click path).
  - WAIT2:
    - btn_pressed goes to PRESS2.
    - Otherwise, at ms == DOUBLE_MS: pulse single_click and go to IDLE.
    - Press in the same cycle as the timeout: press wins.
  - PRESS2:
    - btn_released: pulse double_click and go to IDLE.
    - At ms == LONG_MS with no release: pulse long_press (no double_click) and go to LONG_HOLD.
  - LONG_HOLD:
    - btn_released goes to IDLE; no pulse.
    - If btn_state reads 0 while in this state (lost release pulse), go to IDLE anyway.
- Output timing: all outputs are registered. A pulse is high in the cycle after the deciding condition and lasts exactly 1 cycle. At most one of single_click, double_click, long_press is high in any cycle.
- busy is registered and reflects the current state (state != IDLE).
- A reset asserted mid-gesture aborts it with no pulse. Events in the reset cycle are dropped.

Optional Feature:
- Macro: CLICK_DECODER_REPEAT_EN.
- Defined:
  - In LONG_HOLD, repeat_tick pulses every REPEAT_MS*CPM cycles.
  - The first repeat_tick comes REPEAT_MS after long_press.
  - Repeats continue until release; a release on the repeat boundary suppresses that repeat.
- Undefined: repeat_tick is tied to 0 and there is no repeat counter logic.

Decomposition:
- Package click_decoder_pkg:
  - typedef enum logic [2:0] click_state_t {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD}.
  - localparam function for the ms-counter width.
- Sub-module click_ms_tick:
  - Prescaler with a sync clear input, parameter CPM, output tick.
  - Instantiated once.

Test Plan:
Bench uses CLK_HZ=10_000 (CPM=10), LONG_MS=50, DOUBLE_MS=20, REPEAT_MS=10.
1. Press at cycle 0, release at cycle 100 -> single_click high at exactly cycle 100+200+1; no other pulse; busy low afterwards.
2. Press at 0, release at 50, press at 150, release at 200 -> double_click at cycle 201; no single_click.
3. Press at 0, held -> long_press at cycle 501; release at 900 -> no further pulse, busy drops at 901. With repeat enabled: repeat_tick at 601, 701, 801.
4. Boundary cases:
   - Release exactly at cycle 500 in PRESS1 -> no long_press; single_click 200 cycles later.
   - Press exactly on the WAIT2 timeout cycle -> PRESS2 entered, no single_click.
5. Abort and hold-at-reset:
   - rst asserted for 1 cycle during WAIT2 -> no pulses, busy=0 the next cycle.
   - btn_state=1 at reset with no btn_pressed -> stays IDLE, no outputs.
6. Second press held 500 cycles -> long_press only, no double_click. Also: pressed and released in the same cycle from IDLE -> ignored, busy stays 0.
